block_mem_responder: RTL
========================

// Module: block_mem_responder
// PURPOSE
//  Main-memory responder on the cache<->memory block interface; the cache is the initiator.
//  - Serves line fills (read bursts) and dirty write-backs (write bursts) of BLOCK_WORDS words, after a fixed access latency.
//  - Holds the word-addressed data array that the top-level bench inspects.
// PARAMETERS
//  WORD_W       32  data word width
//  DEPTH_WORDS  64  array size in words; must be a multiple of BLOCK_WORDS
//  BLOCK_WORDS  4   words per cache block (power of 2)
//  LATENCY      3   access delay in cycles, >=1
//  ADDR_W       derived = log2(DEPTH_WORDS/BLOCK_WORDS); block-address width (4 at defaults)
// PORTS
//  clock        in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  req_valid    in   1       cache request valid
//  req_ready    out  1       responder idle; request accepted when req_valid && req_ready
//  req_write    in   1       1 = write-back, 0 = line fill
//  req_addr     in   ADDR_W  block address; word base = req_addr*BLOCK_WORDS
//  wdata        in   WORD_W  write-back beat data
//  wdata_valid  in   1       write beat valid
//  wdata_ready  out  1       responder accepting write beats
//  rdata        out  WORD_W  fill beat data; 0 when rdata_valid=0
//  rdata_valid  out  1       fill beat valid; the cache always accepts, no backpressure
//  rdata_last   out  1       marks final fill beat
//  wr_done      out  1       one-cycle pulse: write-back committed
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM->IDLE, latency/beat counters 0, req_ready=1, all other outputs 0.
//  - Array contents are NOT touched by reset. Reset mid-burst aborts the burst; words already written stay written.
//  - FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT.
//  - IDLE: req_ready=1. On accept, latch req_addr (and start word), beat=0, then:
//    - req_write=0 -> RD_WAIT
//    - req_write=1 -> WR_BURST
//  - RD_WAIT: stay LATENCY cycles, then ->RD_BURST. The first beat appears LATENCY+1 cycles after the accept edge.
//  - RD_BURST: one beat per cycle, BLOCK_WORDS consecutive cycles.
//    - rdata = mem[base+word], where word = (start+beat) mod BLOCK_WORDS.
//    - rdata_last=1 on beat BLOCK_WORDS-1, then ->IDLE.
//  - WR_BURST: wdata_ready=1. Each cycle with wdata_valid=1 writes mem[base+beat] and increments beat.
//    - Gaps (wdata_valid=0) are allowed and stall the burst.
//    - After the last beat is written -> WR_WAIT.
//  - WR_WAIT: stay LATENCY cycles, then pulse wr_done for 1 cycle and ->IDLE.
//  - Busy (any state except IDLE): req_ready=0; req_valid is ignored and the cache must hold it.
//  - wdata_valid outside WR_BURST: ignored, no array write.
//  - Beat counter: log2(BLOCK_WORDS) bits; wraps modulo BLOCK_WORDS.
//  - Address arithmetic: base+word never exceeds DEPTH_WORDS-1 by construction.
//  - Back-to-back: a new request can be accepted on the cycle after rdata_last or after wr_done (IDLE for at least 1 cycle).
//  - Read latency is fixed for every fill, independent of data or address.
// CONFIGURATION
//  - Macro CRIT_WORD_FIRST_EN.
//  - Defined: extra input port req_word [log2(BLOCK_WORDS)-1:0], latched on accept as start. The fill burst begins at that word and wraps, e.g. 2,3,0,1.
//  - Undefined: port absent, start=0, fill order always 0..BLOCK_WORDS-1.
//  - Write-back order is always 0..BLOCK_WORDS-1 in both builds.
// TESTING
//  - Reset: hold reset_n=0 for 2 cycles, then release.
//    -> req_ready=1, rdata_valid=0, wdata_ready=0, wr_done=0, rdata=0; preloaded mem[i]=i unchanged.
//  - Fill: mem[i]=i, read req_addr=3, LATENCY=3.
//    -> beats 12,13,14,15 on cycles 4..7 after accept; rdata_last only with 15; req_ready=1 on cycle 8.
//  - Write-back: write req_addr=1 with beats 100,101,(gap),102,103.
//    -> mem[4..7]=100..103; wr_done pulses 3 cycles after beat 103; mem[8] unchanged.
//  - Busy / ignored inputs: req_valid asserted during RD_BURST -> not accepted until IDLE.
//    - wdata_valid=1 with wdata=55 during IDLE -> no array change.
//  - Reset mid-write: reset_n=0 after 2 of 4 write beats to block 2.
//    -> mem[8],mem[9] updated, mem[10],mem[11] unchanged, FSM IDLE, wr_done never pulses.
//  - Critical word first (CRIT_WORD_FIRST_EN defined): read req_addr=0, req_word=2.
//    -> beats 2,3,0,1; rdata_last with 1.

Source files
------------

// File: rtl/block_mem_responder.sv
`default_nettype none
// =============================================================================
// Module   : block_mem_responder
// Desc     : Main-memory responder serving cache line fills and dirty write-backs
//            after a fixed access latency. Optional macro CRIT_WORD_FIRST_EN adds
//            req_word so fills start at the critical word and wrap.
// Revision : 1.0
// =============================================================================
module block_mem_responder #(
   parameter int WORD_W      = 32,
   parameter int DEPTH_WORDS = 64,
   parameter int BLOCK_WORDS = 4,
   parameter int LATENCY     = 3,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS / BLOCK_WORDS),
   parameter int BEAT_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
`ifdef CRIT_WORD_FIRST_EN
   input  logic [BEAT_W-1:0] req_word,
`endif
   input  logic [WORD_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [WORD_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              rdata_last,
   output logic              wr_done
);

   localparam int                c_LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int                c_MEM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(LATENCY - 1);
   localparam logic [BEAT_W-1:0]  c_BEAT_LAST = BEAT_W'(BLOCK_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_RD_BURST = 3'd2,
      ST_WR_BURST = 3'd3,
      ST_WR_WAIT  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_LAT_W-1:0]  r_lat;
   logic [c_LAT_W-1:0]  w_lat_nxt;
   logic [BEAT_W-1:0]   r_beat;
   logic [BEAT_W-1:0]   w_beat_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [BEAT_W-1:0]   r_start;
   logic [BEAT_W-1:0]   w_start_in;
   logic [BEAT_W-1:0]   w_rd_word;
   logic [c_MEM_AW-1:0] w_rd_idx;
   logic [c_MEM_AW-1:0] w_wr_idx;
   logic                w_accept;
   logic                w_mem_we;
   logic [WORD_W-1:0]   r_mem [DEPTH_WORDS];

`ifdef CRIT_WORD_FIRST_EN
   assign w_start_in = req_word;
`else
   assign w_start_in = '0;
`endif

   assign w_accept  = (r_state == ST_IDLE) && req_valid;
   // Beat-width addition wraps the fill order around the block boundary.
   assign w_rd_word = r_start + r_beat;
   assign w_rd_idx  = c_MEM_AW'(r_addr) * c_MEM_AW'(BLOCK_WORDS) + c_MEM_AW'(w_rd_word);
   assign w_wr_idx  = c_MEM_AW'(r_addr) * c_MEM_AW'(BLOCK_WORDS) + c_MEM_AW'(r_beat);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_lat   <= '0;
         r_beat  <= '0;
         r_addr  <= '0;
         r_start <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lat   <= w_lat_nxt;
         r_beat  <= w_beat_nxt;
         if (w_accept) begin
            r_addr  <= req_addr;
            r_start <= w_start_in;
         end
      end
   end

   // The array is deliberately outside the reset domain so a reset keeps its contents.
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         r_mem[w_wr_idx] <= wdata;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lat_nxt   = r_lat;
      w_beat_nxt  = r_beat;
      w_mem_we    = 1'b0;
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata       = '0;
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
      wr_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_beat_nxt  = '0;
               w_lat_nxt   = '0;
               w_state_nxt = req_write ? ST_WR_BURST : ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (r_lat == c_LAT_LAST) begin
               w_lat_nxt   = '0;
               w_state_nxt = ST_RD_BURST;
            end else begin
               w_lat_nxt = r_lat + c_LAT_W'(1);
            end
         end
         ST_RD_BURST: begin
            rdata_valid = 1'b1;
            rdata       = r_mem[w_rd_idx];
            w_beat_nxt  = r_beat + BEAT_W'(1);
            if (r_beat == c_BEAT_LAST) begin
               rdata_last  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WR_BURST: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               w_mem_we   = 1'b1;
               w_beat_nxt = r_beat + BEAT_W'(1);
               if (r_beat == c_BEAT_LAST) begin
                  w_lat_nxt   = '0;
                  w_state_nxt = ST_WR_WAIT;
               end
            end
         end
         ST_WR_WAIT: begin
            // wr_done is raised during the final latency cycle, then IDLE follows.
            if (r_lat == c_LAT_LAST) begin
               wr_done     = 1'b1;
               w_lat_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_lat_nxt = r_lat + c_LAT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
